serdesphy_rx_fifo_ctrl: RTL and testbench

Read-side sequencer for the RX elastic FIFO, in the 24 MHz system clock domain. It gates FIFO reads on link enable and CDR lock, and waits a priming interval so the synchronised pointers settle. It then drains bytes into a registered valid/ready output stage. On a sticky overflow/underflow error, lock loss or software request it flushes the FIFO, pulses a FIFO reset and re-primes, keeping byte and error statistics.

---
 rtl/serdesphy_rx_fifo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_serdesphy_rx_fifo_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_rx_fifo_ctrl.sv
// Read-side sequencer for the RX elastic FIFO: gates reads on enable/CDR lock,
// primes after pointer sync, streams into a registered valid/ready stage, and flushes/recovers on errors.
module serdesphy_rx_fifo_ctrl #(
  parameter int PRIME_CYCLES = 8,
  parameter int FLUSH_MAX    = 32,
  parameter int RST_CYCLES   = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cdr_lock,
  input  logic                 sw_flush,
  output logic                 fifo_rd_enable,
  output logic                 fifo_pop,
  output logic                 fifo_rst,
  input  logic [7:0]           fifo_rd_data,
  input  logic                 fifo_rd_valid,
  input  logic                 fifo_empty,
  input  logic                 fifo_overflow,
  input  logic                 fifo_underflow,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] byte_count,
  output logic [7:0]           err_count,
  output logic                 streaming
);

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_PRIME   = 3'd1;
  localparam logic [2:0] ST_STREAM  = 3'd2;
  localparam logic [2:0] ST_FLUSH   = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  localparam int TMR_MAX_A = (PRIME_CYCLES > FLUSH_MAX) ? PRIME_CYCLES : FLUSH_MAX;
  localparam int TMR_MAX   = (TMR_MAX_A > RST_CYCLES) ? TMR_MAX_A : RST_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] PRIME_LOAD = TMR_W'(PRIME_CYCLES - 1);
  localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_MAX - 1);
  localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);

  logic [2:0]           ret_q;
  logic [TMR_W-1:0]     tmr_q;
  logic                 empty_q;
  logic [7:0]           data_p1;
  logic                 vld_p1;
  logic [CNT_WIDTH-1:0] byte_cnt_q;
  logic [7:0]           err_cnt_q;

  logic err_hit;
  logic stream_exit;
  logic flush_done;
  logic handshake;
  logic pop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Exit conditions win over pop: no byte leaves the FIFO in the cycle STREAM is abandoned
  assign err_hit     = fifo_overflow || fifo_underflow || !cdr_lock;
  assign stream_exit = err_hit || sw_flush || !enable;
  assign flush_done  = (fifo_empty && empty_q) || (tmr_q == '0);
  assign handshake   = vld_p1 && out_ready;

  always_comb begin
    pop = 1'b0;
    case (state)
      ST_STREAM: pop = !stream_exit && fifo_rd_valid && (!vld_p1 || out_ready);
      ST_FLUSH:  pop = fifo_rd_valid;
      default:   pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_OFF;
      ret_q   <= ST_OFF;
      tmr_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      case (state)
        ST_OFF: begin
          if (enable && cdr_lock) begin
            state <= ST_PRIME;
            tmr_q <= PRIME_LOAD;
          end
        end
        ST_PRIME: begin
          if (!enable || !cdr_lock)   state <= ST_OFF;
          else if (tmr_q == '0)       state <= ST_STREAM;
          else                        tmr_q <= tmr_q - TMR_W'(1);
        end
        ST_STREAM: begin
          if (stream_exit) begin
            state   <= ST_FLUSH;
            tmr_q   <= FLUSH_LOAD;
            empty_q <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (flush_done) begin
            state <= ST_RECOVER;
            tmr_q <= RST_LOAD;
            ret_q <= (!enable || !cdr_lock) ? ST_OFF : ST_PRIME;
          end else begin
            tmr_q   <= tmr_q - TMR_W'(1);
            empty_q <= fifo_empty;
          end
        end
        ST_RECOVER: begin
          // Link conditions are re-evaluated only once the target state is reached
          if (tmr_q == '0) begin
            state <= ret_q;
            tmr_q <= PRIME_LOAD;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  // Output stage p1: one cycle from FIFO head to out_valid, held under backpressure
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_p1 <= 8'h00;
      vld_p1  <= 1'b0;
    end else if (state == ST_STREAM) begin
      if (stream_exit) begin
        vld_p1 <= 1'b0;
      end else if (pop) begin
        data_p1 <= fifo_rd_data;
        vld_p1  <= 1'b1;
      end else if (handshake) begin
        vld_p1 <= 1'b0;
      end
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      err_cnt_q  <= 8'h00;
    end else begin
      if (handshake)                       byte_cnt_q <= byte_cnt_q + CNT_WIDTH'(1);
      if (state == ST_STREAM && err_hit)   err_cnt_q  <= sat_inc8(err_cnt_q);
    end
  end

  assign fifo_rd_enable = (state == ST_PRIME) || (state == ST_STREAM) || (state == ST_FLUSH);
  assign fifo_pop       = pop;
  assign fifo_rst       = (state == ST_RECOVER);
  assign out_data       = data_p1;
  assign out_valid      = vld_p1;
  assign byte_count     = byte_cnt_q;
  assign err_count      = err_cnt_q;
  assign streaming      = (state == ST_STREAM);

endmodule

// File: tb/tb_serdesphy_rx_fifo_ctrl.sv
// Bench for serdesphy_rx_fifo_ctrl: queue-based FIFO environment, per-cycle reference model,
// a vector table for priming/streaming and directed sequences for recovery corner cases.
module tb_serdesphy_rx_fifo_ctrl;
  localparam int PRIME_CYCLES = 8;
  localparam int FLUSH_MAX    = 32;
  localparam int RST_CYCLES   = 4;
  localparam int CNT_WIDTH    = 16;

  logic clk, rst, enable, cdr_lock, sw_flush;
  logic fifo_rd_enable, fifo_pop, fifo_rst;
  logic [7:0] fifo_rd_data;
  logic fifo_rd_valid, fifo_empty, fifo_overflow, fifo_underflow;
  logic [7:0] out_data;
  logic out_valid, out_ready;
  logic [2:0] state;
  logic [CNT_WIDTH-1:0] byte_count;
  logic [7:0] err_count;
  logic streaming;

  serdesphy_rx_fifo_ctrl #(
    .PRIME_CYCLES(PRIME_CYCLES), .FLUSH_MAX(FLUSH_MAX),
    .RST_CYCLES(RST_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cdr_lock(cdr_lock), .sw_flush(sw_flush),
    .fifo_rd_enable(fifo_rd_enable), .fifo_pop(fifo_pop), .fifo_rst(fifo_rst),
    .fifo_rd_data(fifo_rd_data), .fifo_rd_valid(fifo_rd_valid), .fifo_empty(fifo_empty),
    .fifo_overflow(fifo_overflow), .fifo_underflow(fifo_underflow),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .state(state), .byte_count(byte_count), .err_count(err_count), .streaming(streaming)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  logic [7:0] got[$];
  bit ov_f, un_f;
  bit pop_seen, rst_seen;

  // Reference model: mode, cycles spent in mode, consecutive-empty run, output slot, counters
  int m_mode, m_age, m_erun, m_ret, m_vld, m_data, m_bytes, m_errs;
  bit m_pop;

  typedef struct {
    bit         en;
    bit         lk;
    bit         rdy;
    logic [2:0] st;
    bit         vld;
    logic [7:0] dat;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_rd_valid  = (q.size() != 0);
    fifo_empty     = (q.size() == 0);
    fifo_rd_data   = (q.size() != 0) ? q[0] : 8'h00;
    fifo_overflow  = ov_f;
    fifo_underflow = un_f;
  endtask

  task automatic model_reset();
    m_mode = 0; m_age = 0; m_erun = 0; m_ret = 0;
    m_vld = 0; m_data = 0; m_bytes = 0; m_errs = 0;
  endtask

  task automatic model_step();
    bit rdv, emp, err;
    rdv = (q.size() != 0);
    emp = !rdv;
    m_pop = 1'b0;
    if (m_vld != 0 && out_ready) m_bytes = (m_bytes + 1) % (1 << CNT_WIDTH);
    case (m_mode)
      0: if (enable && cdr_lock) begin m_mode = 1; m_age = 0; end
      1: begin
        if (!enable || !cdr_lock) m_mode = 0;
        else if (m_age == PRIME_CYCLES - 1) m_mode = 2;
        else m_age++;
      end
      2: begin
        err = fifo_overflow || fifo_underflow || !cdr_lock;
        if (err || sw_flush || !enable) begin
          m_mode = 3; m_vld = 0; m_age = 0; m_erun = 0;
          if (err && m_errs < 255) m_errs++;
        end else begin
          m_pop = rdv && (m_vld == 0 || out_ready);
          if (m_pop) begin m_vld = 1; m_data = q[0]; end
          else if (m_vld != 0 && out_ready) m_vld = 0;
        end
      end
      3: begin
        m_pop = rdv;
        m_erun = emp ? m_erun + 1 : 0;
        if (m_erun >= 2 || m_age == FLUSH_MAX - 1) begin
          m_ret = (!enable || !cdr_lock) ? 0 : 1;
          m_mode = 4; m_age = 0;
        end else m_age++;
      end
      default: begin
        if (m_age == RST_CYCLES - 1) begin m_mode = m_ret; m_age = 0; end
        else m_age++;
      end
    endcase
  endtask

  // One clock: combinational outputs checked mid-cycle, registered outputs just after the edge
  task automatic cycle();
    @(negedge clk);
    chk("rd_enable", fifo_rd_enable, (m_mode >= 1 && m_mode <= 3));
    chk("fifo_rst", fifo_rst, (m_mode == 4));
    if (out_valid && out_ready) got.push_back(out_data);
    pop_seen = fifo_pop;
    rst_seen = fifo_rst;
    model_step();
    chk("fifo_pop", pop_seen, m_pop);
    @(posedge clk);
    #1;
    if (rst_seen) begin
      q.delete(); ov_f = 0; un_f = 0;
    end else if (pop_seen && q.size() != 0) begin
      void'(q.pop_front());
    end
    drive_fifo();
    chk("state", state, m_mode);
    chk("out_valid", out_valid, m_vld);
    if (m_vld != 0) chk("out_data", out_data, m_data);
    chk("byte_count", byte_count, m_bytes);
    chk("err_count", err_count, m_errs);
    chk("streaming", streaming, (m_mode == 2));
  endtask

  task automatic wait_state(input int s, input int maxc, input string nm);
    int n;
    n = 0;
    while (int'(state) != s && n < maxc) begin
      cycle();
      n++;
    end
    chk(nm, state, s);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, nrst;
    for (int i = 0; i < 14; i++) begin
      tbl[i].en  = 1'b1;
      tbl[i].lk  = 1'b1;
      tbl[i].rdy = 1'b1;
      tbl[i].st  = (i < 8) ? 3'd1 : 3'd2;
      tbl[i].vld = (i >= 9 && i <= 11);
      case (i)
        9:       tbl[i].dat = 8'hA5;
        10:      tbl[i].dat = 8'h5A;
        11:      tbl[i].dat = 8'h3C;
        default: tbl[i].dat = 8'h00;
      endcase
    end

    rst = 1'b1; enable = 0; cdr_lock = 0; sw_flush = 0; out_ready = 0;
    ov_f = 0; un_f = 0;
    drive_fifo();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_rd_enable", fifo_rd_enable, 0);
    chk("rst_fifo_rst", fifo_rst, 0);
    chk("rst_fifo_pop", fifo_pop, 0);
    rst = 1'b0;

    // Prime and stream three bytes
    q.push_back(8'hA5); q.push_back(8'h5A); q.push_back(8'h3C);
    drive_fifo();
    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en; cdr_lock = tbl[i].lk; out_ready = tbl[i].rdy;
      cycle();
      chk("tbl_state", state, tbl[i].st);
      chk("tbl_valid", out_valid, tbl[i].vld);
      if (tbl[i].vld) chk("tbl_data", out_data, tbl[i].dat);
    end
    chk("prime_byte_count", byte_count, 3);

    // Backpressure
    out_ready = 0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
    drive_fifo();
    cycle();
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_data", out_data, 8'h11);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h11);
      chk("bp_no_pop", pop_seen, 0);
    end
    got.delete();
    out_ready = 1;
    repeat (6) cycle();
    chk("bp_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("bp_b0", got[0], 8'h11); chk("bp_b1", got[1], 8'h22);
      chk("bp_b2", got[2], 8'h33); chk("bp_b3", got[3], 8'h44);
    end
    chk("bp_byte_count", byte_count, 7);

    // Overflow recovery
    out_ready = 0;
    q.push_back(8'hAA); q.push_back(8'hBB); q.push_back(8'hCC);
    drive_fifo();
    cycle();
    ov_f = 1; drive_fifo();
    cycle();
    chk("ovf_state", state, 3);
    chk("ovf_valid", out_valid, 0);
    chk("ovf_err", err_count, 1);
    wait_state(4, 40, "ovf_to_recover");
    nrst = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (rst_seen) nrst++;
    end
    chk("ovf_rst_cycles", nrst, RST_CYCLES);
    wait_state(2, 20, "ovf_reprime");

    // Lock loss mid-stream
    q.push_back(8'h01); q.push_back(8'h02); drive_fifo();
    cycle();
    cdr_lock = 0;
    cycle();
    chk("lock_state", state, 3);
    chk("lock_err", err_count, 2);
    wait_state(0, 60, "lock_to_off");
    chk("lock_streaming", streaming, 0);

    // sw_flush ignored in PRIME, honoured in STREAM without an error count; flush timeout
    cdr_lock = 1;
    cycle();
    sw_flush = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("sw_prime_state", state, 1);
    end
    sw_flush = 0;
    wait_state(2, 20, "sw_to_stream");
    for (int i = 0; i < 40; i++) q.push_back(8'(i + 8'h40));
    drive_fifo();
    cycle();
    sw_flush = 1;
    cycle();
    sw_flush = 0;
    chk("sw_stream_state", state, 3);
    chk("sw_stream_err", err_count, 2);
    n = 0;
    while (state == 3'd3 && n < 60) begin
      cycle();
      n++;
    end
    chk("flush_timeout_cycles", n, FLUSH_MAX);
    chk("flush_timeout_state", state, 4);

    // Asynchronous reset mid-stream
    wait_state(2, 30, "pre_async_stream");
    q.push_back(8'h77); drive_fifo();
    cycle();
    #3;
    rst = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_valid", out_valid, 0);
    chk("async_bytes", byte_count, 0);
    chk("async_err", err_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    q.delete(); ov_f = 0; un_f = 0;
    drive_fifo();

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      enable    = ($urandom_range(0, 99) < 97);
      cdr_lock  = ($urandom_range(0, 99) < 97);
      sw_flush  = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 1) ov_f = 1;
      if ($urandom_range(0, 199) < 1) un_f = 1;
      if (!fifo_rst && q.size() < 16 && $urandom_range(0, 1) == 1) q.push_back(8'($urandom));
      drive_fifo();
      cycle();
    end

    // Error counter saturation
    enable = 1; cdr_lock = 1; sw_flush = 0; out_ready = 1;
    for (int i = 0; i < 300; i++) begin
      wait_state(2, 80, "sat_stream");
      ov_f = 1; drive_fifo();
      cycle();
    end
    chk("err_saturate", err_count, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
